// File: rtl/sdram_pkg.sv
// sdram_pkg
// Shared definitions for the SDRAM controller slice.
//   - Command encodings, given as {cs_n, ras_n, cas_n, we_n}.
//   - Arbiter state encoding.
package sdram_pkg;

    localparam logic [3:0] CMD_NOP  = 4'b0111;
    localparam logic [3:0] CMD_PRE  = 4'b0010;
    localparam logic [3:0] CMD_AREF = 4'b0001;

    typedef enum logic [2:0] {
        INIT  = 3'd0,
        ARBIT = 3'd1,
        AREF  = 3'd2,
        WRITE = 3'd3,
        READ  = 3'd4
    } arb_state_t;

endpackage

// File: rtl/sdram_arbit.sv
// sdram_arbit
// Central arbiter of the SDRAM controller. It grants one command generator
// at a time, with fixed priority refresh > write > read. Each grant is a
// one-cycle enable pulse. The arbiter returns to arbitration when it sees the
// owner's end flag. It muxes the owner's command, bank and address onto the
// SDRAM pins. A watchdog forces a return to arbitration when an operation
// hangs, and it raises a sticky error flag.
//
// Ports:
//   sclk, s_rst_n                 clock; synchronous active-low reset
//   flag_init_end                 init sequence complete (level)
//   init_cmd/init_addr            init generator command/address
//   ref_req/ref_en/flag_ref_end   refresh request, grant pulse, done
//   aref_cmd/aref_addr            refresh generator command/address
//   wr_req/wr_en/flag_wr_end      write request, grant pulse, done
//   wr_cmd/wr_addr/wr_bank        write generator command/address/bank
//   rd_req/rd_en/flag_rd_end      read request, grant pulse, done
//   rd_cmd/rd_addr/rd_bank        read generator command/address/bank
//   sdram_cke                     clock enable, held at 1
//   sdram_cs_n..sdram_we_n        command pins
//   sdram_bank/sdram_addr         bank and address pins
//   arb_err                       sticky watchdog-fired flag
module sdram_arbit
    import sdram_pkg::*;
#(
    parameter int ADDR_W  = 12,
    parameter int TIMEOUT = 1023,
    parameter int CNT_W   = 10
) (
    input  logic              sclk,
    input  logic              s_rst_n,
    input  logic              flag_init_end,
    input  logic [3:0]        init_cmd,
    input  logic [ADDR_W-1:0] init_addr,
    input  logic              ref_req,
    output logic              ref_en,
    input  logic              flag_ref_end,
    input  logic [3:0]        aref_cmd,
    input  logic [ADDR_W-1:0] aref_addr,
    input  logic              wr_req,
    output logic              wr_en,
    input  logic              flag_wr_end,
    input  logic [3:0]        wr_cmd,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [1:0]        wr_bank,
    input  logic              rd_req,
    output logic              rd_en,
    input  logic              flag_rd_end,
    input  logic [3:0]        rd_cmd,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic [1:0]        rd_bank,
    output logic              sdram_cke,
    output logic              sdram_cs_n,
    output logic              sdram_ras_n,
    output logic              sdram_cas_n,
    output logic              sdram_we_n,
    output logic [1:0]        sdram_bank,
    output logic [ADDR_W-1:0] sdram_addr,
    output logic              arb_err
);

    arb_state_t        state_reg, state_next;
    logic [CNT_W-1:0]  wdog_reg, wdog_next;
    logic              ref_en_reg, wr_en_reg, rd_en_reg;
    logic              arb_err_reg;
    logic              wdog_expired;
    logic              timeout_fire;
    logic [3:0]        cmd_mux;

    // wdog_reg holds the number of cycles already completed in the current
    // state. It expires in the TIMEOUT-th cycle, so an owner keeps the bus
    // for at most TIMEOUT cycles.
    assign wdog_expired = (wdog_reg == CNT_W'(TIMEOUT - 1));

    // Next-state logic
    always_comb begin
        state_next   = state_reg;
        timeout_fire = 1'b0;
        case (state_reg)
            INIT: begin
                if (flag_init_end)
                    state_next = ARBIT;
            end
            ARBIT: begin
                if (ref_req)
                    state_next = AREF;
                else if (wr_req)
                    state_next = WRITE;
                else if (rd_req)
                    state_next = READ;
            end
            AREF: begin
                if (flag_ref_end) begin
                    state_next = ARBIT;
                end else if (wdog_expired) begin
                    state_next   = ARBIT;
                    timeout_fire = 1'b1;
                end
            end
            WRITE: begin
                if (flag_wr_end) begin
                    state_next = ARBIT;
                end else if (wdog_expired) begin
                    state_next   = ARBIT;
                    timeout_fire = 1'b1;
                end
            end
            READ: begin
                if (flag_rd_end) begin
                    state_next = ARBIT;
                end else if (wdog_expired) begin
                    state_next   = ARBIT;
                    timeout_fire = 1'b1;
                end
            end
            default: state_next = INIT;
        endcase
    end

    // Watchdog: clears on any state change, and counts only while a
    // generator owns the bus.
    always_comb begin
        wdog_next = wdog_reg;
        if (state_next != state_reg)
            wdog_next = '0;
        else if (state_reg == AREF || state_reg == WRITE || state_reg == READ)
            wdog_next = wdog_reg + CNT_W'(1);
    end

    always_ff @(posedge sclk) begin
        if (!s_rst_n) begin
            state_reg   <= INIT;
            wdog_reg    <= '0;
            ref_en_reg  <= 1'b0;
            wr_en_reg   <= 1'b0;
            rd_en_reg   <= 1'b0;
            arb_err_reg <= 1'b0;
        end else begin
            state_reg  <= state_next;
            wdog_reg   <= wdog_next;
            // Only ARBIT leads into an owner state. A pulse therefore marks
            // the first cycle of ownership, and at most one pulse is high.
            ref_en_reg <= (state_reg == ARBIT) && (state_next == AREF);
            wr_en_reg  <= (state_reg == ARBIT) && (state_next == WRITE);
            rd_en_reg  <= (state_reg == ARBIT) && (state_next == READ);
            if (timeout_fire)
                arb_err_reg <= 1'b1;
        end
    end

    // Pin mux, decoded from the registered state
    always_comb begin
        cmd_mux    = CMD_NOP;
        sdram_bank = 2'd0;
        sdram_addr = '0;
        case (state_reg)
            INIT: begin
                cmd_mux    = init_cmd;
                sdram_addr = init_addr;
            end
            AREF: begin
                cmd_mux    = aref_cmd;
                sdram_addr = aref_addr;
            end
            WRITE: begin
                cmd_mux    = wr_cmd;
                sdram_bank = wr_bank;
                sdram_addr = wr_addr;
            end
            READ: begin
                cmd_mux    = rd_cmd;
                sdram_bank = rd_bank;
                sdram_addr = rd_addr;
            end
            default: begin
                cmd_mux    = CMD_NOP;
                sdram_bank = 2'd0;
                sdram_addr = '0;
            end
        endcase
    end

    assign {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} = cmd_mux;
    assign sdram_cke = 1'b1;
    assign ref_en    = ref_en_reg;
    assign wr_en     = wr_en_reg;
    assign rd_en     = rd_en_reg;
    assign arb_err   = arb_err_reg;

endmodule

// File: tb/tb_sdram_arbit.sv
module tb_sdram_arbit;

    localparam int ADDR_W  = 12;
    localparam int TIMEOUT = 1023;

    logic              sclk = 1'b0;
    logic              s_rst_n;
    logic              flag_init_end;
    logic [3:0]        init_cmd;
    logic [ADDR_W-1:0] init_addr;
    logic              ref_req, ref_en, flag_ref_end;
    logic [3:0]        aref_cmd;
    logic [ADDR_W-1:0] aref_addr;
    logic              wr_req, wr_en, flag_wr_end;
    logic [3:0]        wr_cmd;
    logic [ADDR_W-1:0] wr_addr;
    logic [1:0]        wr_bank;
    logic              rd_req, rd_en, flag_rd_end;
    logic [3:0]        rd_cmd;
    logic [ADDR_W-1:0] rd_addr;
    logic [1:0]        rd_bank;
    logic              sdram_cke, sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n;
    logic [1:0]        sdram_bank;
    logic [ADDR_W-1:0] sdram_addr;
    logic              arb_err;

    int checks = 0;
    int errors = 0;

    always #5 sclk = ~sclk;

    sdram_arbit #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT), .CNT_W(10)) dut (
        .sclk(sclk), .s_rst_n(s_rst_n), .flag_init_end(flag_init_end),
        .init_cmd(init_cmd), .init_addr(init_addr),
        .ref_req(ref_req), .ref_en(ref_en), .flag_ref_end(flag_ref_end),
        .aref_cmd(aref_cmd), .aref_addr(aref_addr),
        .wr_req(wr_req), .wr_en(wr_en), .flag_wr_end(flag_wr_end),
        .wr_cmd(wr_cmd), .wr_addr(wr_addr), .wr_bank(wr_bank),
        .rd_req(rd_req), .rd_en(rd_en), .flag_rd_end(flag_rd_end),
        .rd_cmd(rd_cmd), .rd_addr(rd_addr), .rd_bank(rd_bank),
        .sdram_cke(sdram_cke), .sdram_cs_n(sdram_cs_n), .sdram_ras_n(sdram_ras_n),
        .sdram_cas_n(sdram_cas_n), .sdram_we_n(sdram_we_n),
        .sdram_bank(sdram_bank), .sdram_addr(sdram_addr), .arb_err(arb_err)
    );

    // Fixed, distinct generator outputs, so each pin pattern shows its owner
    localparam logic [3:0]  I_CMD = 4'b0010, A_CMD = 4'b0001, W_CMD = 4'b0100, R_CMD = 4'b0101;
    localparam logic [11:0] I_ADR = 12'h400, A_ADR = 12'h111, W_ADR = 12'h0AB, R_ADR = 12'h2CD;
    localparam logic [1:0]  W_BNK = 2'd2, R_BNK = 2'd1;
    localparam logic [3:0]  NOP = 4'b0111;

    typedef struct {
        logic        rst_n, fi, rref, rwr, rrd, eref, ewr, erd;
        logic        xref, xwr, xrd;
        logic [3:0]  xcmd;
        logic [1:0]  xbank;
        logic [11:0] xaddr;
        logic        xerr;
    } vec_t;

    vec_t vt[21];

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @%0d: got %0h expected %0h", nm, idx, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [7:0] in, input logic [2:0] en,
                                input logic [3:0] cmd, input logic [1:0] bank,
                                input logic [11:0] addr, input logic err);
        vec_t v;
        {v.rst_n, v.fi, v.rref, v.rwr, v.rrd, v.eref, v.ewr, v.erd} = in;
        {v.xref, v.xwr, v.xrd} = en;
        v.xcmd = cmd; v.xbank = bank; v.xaddr = addr; v.xerr = err;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        s_rst_n = v.rst_n; flag_init_end = v.fi;
        ref_req = v.rref; wr_req = v.rwr; rd_req = v.rrd;
        flag_ref_end = v.eref; flag_wr_end = v.ewr; flag_rd_end = v.erd;
    endtask

    task automatic check_pins(input int idx, input logic [2:0] en, input logic [3:0] cmd,
                              input logic [1:0] bank, input logic [11:0] addr, input logic err);
        chk("ref_en", idx, 32'(ref_en), 32'(en[2]));
        chk("wr_en", idx, 32'(wr_en), 32'(en[1]));
        chk("rd_en", idx, 32'(rd_en), 32'(en[0]));
        chk("cmd", idx, 32'({sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n}), 32'(cmd));
        chk("bank", idx, 32'(sdram_bank), 32'(bank));
        chk("addr", idx, 32'(sdram_addr), 32'(addr));
        chk("arb_err", idx, 32'(arb_err), 32'(err));
        chk("cke", idx, 32'(sdram_cke), 32'd1);
    endtask

    initial begin
        int n_read;
        bit left;
        init_cmd = I_CMD; init_addr = I_ADR;
        aref_cmd = A_CMD; aref_addr = A_ADR;
        wr_cmd = W_CMD; wr_addr = W_ADR; wr_bank = W_BNK;
        rd_cmd = R_CMD; rd_addr = R_ADR; rd_bank = R_BNK;
        s_rst_n = 1'b0; flag_init_end = 0; ref_req = 0; wr_req = 0; rd_req = 0;
        flag_ref_end = 0; flag_wr_end = 0; flag_rd_end = 0;

        // inputs {rst_n,fi,rref,rwr,rrd,eref,ewr,erd}; grants {ref,wr,rd}; expected after the edge
        vt[0]  = mk(8'b0000_0000, 3'b000, I_CMD, 2'd0, I_ADR, 0); // reset -> INIT
        vt[1]  = mk(8'b1001_0000, 3'b000, I_CMD, 2'd0, I_ADR, 0); // wr_req ignored in INIT
        vt[2]  = mk(8'b1001_0000, 3'b000, I_CMD, 2'd0, I_ADR, 0);
        vt[3]  = mk(8'b1101_0000, 3'b000, NOP,   2'd0, 12'h0, 0); // -> ARBIT
        vt[4]  = mk(8'b1101_0000, 3'b010, W_CMD, W_BNK, W_ADR, 0); // -> WRITE, wr_en
        vt[5]  = mk(8'b1101_0001, 3'b000, W_CMD, W_BNK, W_ADR, 0); // rd end ignored
        vt[6]  = mk(8'b1111_1010, 3'b000, NOP,   2'd0, 12'h0, 0); // wr end -> ARBIT
        vt[7]  = mk(8'b1111_1000, 3'b100, A_CMD, 2'd0, A_ADR, 0); // all req -> AREF only
        vt[8]  = mk(8'b1101_1000, 3'b000, A_CMD, 2'd0, A_ADR, 0); // stays in AREF
        vt[9]  = mk(8'b1101_1100, 3'b000, NOP,   2'd0, 12'h0, 0); // ref end -> ARBIT
        vt[10] = mk(8'b1101_1100, 3'b010, W_CMD, W_BNK, W_ADR, 0); // held ref end ignored, WRITE
        vt[11] = mk(8'b1100_1010, 3'b000, NOP,   2'd0, 12'h0, 0); // wr end -> ARBIT
        vt[12] = mk(8'b1100_1000, 3'b001, R_CMD, R_BNK, R_ADR, 0); // -> READ
        vt[13] = mk(8'b1100_0001, 3'b000, NOP,   2'd0, 12'h0, 0); // rd end -> ARBIT
        vt[14] = mk(8'b1100_0001, 3'b000, NOP,   2'd0, 12'h0, 0); // held rd end, no req
        vt[15] = mk(8'b1100_1100, 3'b001, R_CMD, R_BNK, R_ADR, 0); // ref end in ARBIT ignored
        vt[16] = mk(8'b1100_0110, 3'b000, R_CMD, R_BNK, R_ADR, 0); // foreign end flags ignored
        vt[17] = mk(8'b1100_0001, 3'b000, NOP,   2'd0, 12'h0, 0); // -> ARBIT
        vt[18] = mk(8'b1110_0000, 3'b100, A_CMD, 2'd0, A_ADR, 0); // -> AREF
        vt[19] = mk(8'b0010_0000, 3'b000, I_CMD, 2'd0, I_ADR, 0); // reset mid-AREF -> INIT
        vt[20] = mk(8'b1010_0000, 3'b000, I_CMD, 2'd0, I_ADR, 0); // still INIT without fi

        for (int i = 0; i < 21; i++) begin
            @(negedge sclk);
            drive(vt[i]);
            @(posedge sclk);
            #1;
            $display("vec %0d: en=%b%b%b cmd=%b bank=%0d addr=%03h err=%b", i, ref_en, wr_en, rd_en,
                     {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n}, sdram_bank, sdram_addr, arb_err);
            check_pins(i, {vt[i].xref, vt[i].xwr, vt[i].xrd}, vt[i].xcmd, vt[i].xbank, vt[i].xaddr, vt[i].xerr);
        end

        // Watchdog: enter READ and never send flag_rd_end
        @(negedge sclk);
        s_rst_n = 1; flag_init_end = 1; ref_req = 0; wr_req = 0; rd_req = 1;
        flag_ref_end = 0; flag_wr_end = 0; flag_rd_end = 0;
        @(posedge sclk); #1;
        check_pins(100, 3'b000, NOP, 2'd0, 12'h0, 0);
        @(negedge sclk);
        @(posedge sclk); #1;
        $display("wdog: entered READ rd_en=%b", rd_en);
        check_pins(101, 3'b001, R_CMD, R_BNK, R_ADR, 0);
        @(negedge sclk);
        rd_req = 0;
        n_read = 1;
        left = 0;
        for (int c = 0; c < TIMEOUT + 20 && !left; c++) begin
            @(posedge sclk); #1;
            if (sdram_cas_n == 1'b1 && sdram_we_n == 1'b1) left = 1;
            else begin
                n_read++;
                if (arb_err !== 1'b0) begin
                    checks++; errors++;
                    $display("FAIL wdog_early_err: arb_err=%b in READ cycle %0d, required 0", arb_err, n_read);
                end
            end
        end
        checks++;
        if (!left) begin
            errors++;
            $display("FAIL wdog_timeout: READ never left within %0d cycles", TIMEOUT + 20);
        end
        chk("wdog_cycles", 102, 32'(n_read), 32'(TIMEOUT));
        $display("wdog: READ lasted %0d cycles, arb_err=%b", n_read, arb_err);
        check_pins(103, 3'b000, NOP, 2'd0, 12'h0, 1);
        repeat (100) @(posedge sclk);
        #1;
        $display("wdog: 100 cycles later arb_err=%b", arb_err);
        check_pins(104, 3'b000, NOP, 2'd0, 12'h0, 1);

        // Reset clears the sticky error
        @(negedge sclk);
        s_rst_n = 0;
        @(posedge sclk); #1;
        $display("reset: arb_err=%b", arb_err);
        check_pins(105, 3'b000, I_CMD, 2'd0, I_ADR, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sdram_arbit.md
Name: sdram_arbit

Overview:
- Central arbiter of the SDRAM controller.
- Sits between the command generators (init, auto-refresh, write, read) and the SDRAM pins.
- Grants one generator at a time with fixed priority: refresh > write > read. Issues one-cycle enable pulses and returns to arbitration on each generator's end flag.
- Muxes the granted generator's command/bank/address onto the device bus. Includes a stuck-operation watchdog.

Parameters:
- ADDR_W, 12, SDRAM address bus width.
- TIMEOUT, 1023, max cycles allowed in AREF/WRITE/READ without the matching end flag.
- CNT_W, 10, watchdog counter width; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- sclk  in  1  system clock
- s_rst_n  in  1  reset, synchronous, active-low
- flag_init_end  in  1  init sequence complete (level)
- init_cmd  in  4  {cs_n,ras_n,cas_n,we_n} from init
- init_addr  in  ADDR_W  address from init
- ref_req  in  1  refresh request (level, held until granted)
- ref_en  out  1  refresh grant pulse
- flag_ref_end  in  1  refresh done
- aref_cmd  in  4  refresh command
- aref_addr  in  ADDR_W  refresh address
- wr_req  in  1  write request (level)
- wr_en  out  1  write grant pulse
- flag_wr_end  in  1  write done
- wr_cmd  in  4; wr_addr  in  ADDR_W; wr_bank  in  2
- rd_req  in  1  read request (level)
- rd_en  out  1  read grant pulse
- flag_rd_end  in  1  read done
- rd_cmd  in  4; rd_addr  in  ADDR_W; rd_bank  in  2
- sdram_cke  out  1  constant 1
- sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n  out  1 each  command pins
- sdram_bank  out  2  bank address
- sdram_addr  out  ADDR_W  address
- arb_err  out  1  sticky watchdog-fired flag

Behaviour:
- Reset:
  - All state is reset synchronously on the sclk edge while s_rst_n=0.
  - Resulting values: state=INIT, ref_en/wr_en/rd_en=0, watchdog=0, arb_err=0.
- FSM states: INIT, ARBIT, AREF, WRITE, READ. State and grant pulses are registered.
- INIT:
  - Output mux selects init_cmd/init_addr, bank=0.
  - INIT->ARBIT on the first cycle flag_init_end=1.
  - Requests are ignored while in INIT.
- ARBIT:
  - Outputs NOP (4'b0111), addr=0, bank=0.
  - Priority: ref_req -> AREF; else wr_req -> WRITE; else rd_req -> READ; else stay in ARBIT.
  - Simultaneous requests resolve by priority only; there is no fairness mechanism.
- Grant pulse:
  - On the edge that enters AREF/WRITE/READ, the matching ref_en/wr_en/rd_en goes to 1 for exactly one cycle (the first cycle in that state).
  - At most one grant pulse is high in any cycle.
- AREF/WRITE/READ:
  - The mux passes the owner's cmd/addr (and bank for WRITE/READ; bank=0 for AREF).
  - Return to ARBIT on the first cycle the matching end flag=1.
  - End flags of other generators are ignored.
  - An end flag that remains high after returning to ARBIT is ignored.
- Re-grant:
  - After returning to ARBIT, a new grant can issue on the following edge, so ARBIT occupancy is at least one cycle.
  - A level request still high is granted again.
- Output mux: combinational from the registered state; the command decodes to the four pins in order {cs_n,ras_n,cas_n,we_n}.
- Watchdog:
  - Clears on every state change.
  - Increments each cycle spent in AREF/WRITE/READ.
  - When it reaches TIMEOUT without the end flag, next state is forced to ARBIT and arb_err is set (sticky until reset).
  - The generator is not re-enabled by the timeout itself.
- Reset mid-operation: the FSM returns to INIT and outputs show init_cmd. Upstream generators are expected to be reset by the same s_rst_n.

Decomposition:
- Shared package sdram_pkg holds:
  - command constants CMD_NOP=4'b0111, CMD_PRE=4'b0010, CMD_AREF=4'b0001;
  - the state encoding enum (INIT/ARBIT/AREF/WRITE/READ).
- No sub-module is needed; the watchdog counter stays inline.

Test Plan:
- Hold flag_init_end=0 with wr_req=1 -> state stays INIT, no wr_en, pins show init_cmd. Then set flag_init_end=1 -> ARBIT next cycle and wr_en pulses one cycle later.
- ref_req=wr_req=rd_req=1 in ARBIT -> only ref_en pulses. Pins follow aref_cmd until flag_ref_end, then wr_en pulses, then rd_en after flag_wr_end.
- In WRITE, drive wr_cmd=4'b0100, wr_bank=2'd2, wr_addr=12'h0AB -> cs_n=0, ras_n=1, cas_n=0, we_n=0, bank=2, addr=0x0AB. Assert flag_rd_end -> no effect.
- Hold flag_ref_end high 2 cycles -> single return to ARBIT; the second cycle produces no spurious transition, and a pending rd_req is granted on schedule.
- Enter READ with flag_rd_end never asserted -> after TIMEOUT (1023) cycles state=ARBIT and arb_err=1, still 1 after 100 more cycles.
- Assert s_rst_n=0 for one edge while in AREF -> next cycle state=INIT, all grant pulses 0, arb_err=0.
